// File: rtl/serial_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_cmd_pkg
// Brief   : Shared constants, state encoding and helpers for serial_cmd_port.
// Revision: 1.0 - initial release
// ============================================================================
package serial_cmd_pkg;

    localparam int FRAME_BITS = 40;
    localparam int HDR_BITS   = 8;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 32;
    localparam int RD_LATENCY = 2;
    localparam int CNT_W      = 6;
    localparam int CNT_SAT    = 41;

    localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_HDR   = CNT_W'(HDR_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CNT_SAT);
    localparam logic [1:0]       RD_WAIT   = 2'(RD_LATENCY);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HDR    = 3'd1,
        ST_WDATA  = 3'd2,
        ST_RFETCH = 3'd3,
        ST_RDATA  = 3'd4,
        ST_FLUSH  = 3'd5
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_cmd_port_pin_sync.sv
`default_nettype none
// ============================================================================
// Module  : pin_sync
// Brief   : N-stage pin synchronizer with registered rise/fall detection.
// Revision: 1.0 - initial release
// ============================================================================
module pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    // The chain is deliberately left unreset so a pin that is already high
    // when reset drops does not look like a fresh rising edge.
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic                   r_fall;

    always_ff @(posedge clk) begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
        r_prev <= r_sync[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
            r_fall <= ~r_sync[SYNC_STAGES-1] & r_prev;
        end
    end

    // r_prev is the level aligned with the cycle the edge pulses are valid.
    assign o_level = r_prev;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/serial_cmd_port.sv
`default_nettype none
// ============================================================================
// Module  : serial_cmd_port
// Brief   : Serial command deserializer driving the settings bus and readback.
// Revision: 1.0 - initial release
// ============================================================================
module serial_cmd_port
    import serial_cmd_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              master_clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              sen,
    input  logic              sdi,
    output logic              sdo,
    output logic              sdo_oe,
    output logic [ADDR_W-1:0] serial_addr,
    output logic [DATA_W-1:0] serial_data,
    output logic              serial_strobe,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data
);

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_sen_level,  w_sen_rise,  w_sen_fall;
    logic w_sdi_level,  w_sdi_rise,  w_sdi_fall;
    logic w_unused_pins;

    pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(master_clk), .rst(reset), .i_pin(sclk),
        .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sen (
        .clk(master_clk), .rst(reset), .i_pin(sen),
        .o_level(w_sen_level), .o_rise(w_sen_rise), .o_fall(w_sen_fall)
    );
    pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
        .clk(master_clk), .rst(reset), .i_pin(sdi),
        .o_level(w_sdi_level), .o_rise(w_sdi_rise), .o_fall(w_sdi_fall)
    );

    assign w_unused_pins = &{1'b0, w_sclk_level, w_sdi_rise, w_sdi_fall};

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]   r_ishift, w_ishift_nxt;
    logic [DATA_W-1:0]   r_oshift;
    logic [1:0]          r_wait, w_wait_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic [ADDR_W-1:0]   r_serial_addr;
    logic [DATA_W-1:0]   r_serial_data;
    logic                r_strobe;
    logic                w_active, w_cnt_inc, w_overrun;
    logic                w_hdr_done, w_strobe, w_load;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_ishift_nxt = r_ishift;
        w_wait_nxt   = '0;
        w_hdr_done   = 1'b0;
        w_strobe     = 1'b0;
        w_load       = 1'b0;
        w_active     = (r_state == ST_HDR)    || (r_state == ST_WDATA) ||
                       (r_state == ST_RFETCH) || (r_state == ST_RDATA);
        w_cnt_inc    = w_active && w_sclk_rise;
        w_overrun    = w_cnt_inc && (r_cnt == CNT_FRAME);

        // The bit arriving this cycle is counted before the frame end is judged.
        if (w_cnt_inc) begin
            w_cnt_nxt    = sat_inc(r_cnt);
            w_ishift_nxt = {r_ishift[DATA_W-2:0], w_sdi_level};
        end

        case (r_state)
            ST_IDLE: begin
                if (w_sen_rise) begin
                    w_state_nxt = ST_HDR;
                end else if (w_sen_level) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!w_sen_level) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                if (w_overrun) begin
                    w_state_nxt = w_sen_level ? ST_FLUSH : ST_IDLE;
                end else if (w_sen_fall) begin
                    w_state_nxt = ST_IDLE;
                    w_strobe    = (r_state == ST_WDATA) && (w_cnt_nxt == CNT_FRAME);
                end else begin
                    case (r_state)
                        ST_HDR: begin
                            if (w_cnt_inc && (w_cnt_nxt == CNT_HDR)) begin
                                w_hdr_done  = 1'b1;
                                w_state_nxt = w_ishift_nxt[HDR_BITS-1] ? ST_RFETCH : ST_WDATA;
                            end
                        end
                        ST_RFETCH: begin
                            if (r_wait == RD_WAIT) begin
                                w_load      = 1'b1;
                                w_state_nxt = ST_RDATA;
                            end else begin
                                w_wait_nxt  = r_wait + 2'd1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge master_clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_ishift      <= '0;
            r_oshift      <= '0;
            r_wait        <= '0;
            r_addr        <= '0;
            r_rd_addr     <= '0;
            r_serial_addr <= '0;
            r_serial_data <= '0;
            r_strobe      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= (w_state_nxt == ST_IDLE) ? '0 : w_cnt_nxt;
            r_ishift <= w_ishift_nxt;
            r_wait   <= w_wait_nxt;
            r_strobe <= w_strobe;
            if (w_strobe) begin
                r_serial_addr <= r_addr;
                r_serial_data <= w_ishift_nxt;
            end
            if (w_hdr_done) begin
                r_addr <= w_ishift_nxt[ADDR_W-1:0];
                if (w_ishift_nxt[HDR_BITS-1]) begin
                    r_rd_addr <= w_ishift_nxt[ADDR_W-1:0];
                end
            end
            if (w_load) begin
                r_oshift <= rd_data;
            end else if (r_state == ST_RDATA) begin
                if (w_sclk_fall) begin
                    r_oshift <= {r_oshift[DATA_W-2:0], 1'b0};
                end
            end else begin
                r_oshift <= '0;
            end
        end
    end

    // Gating with the synchronized sen level releases the pad one cycle
    // before the state register leaves RDATA.
    assign sdo_oe        = (r_state == ST_RDATA) && w_sen_level;
    assign sdo           = r_oshift[DATA_W-1];
    assign serial_addr   = r_serial_addr;
    assign serial_data   = r_serial_data;
    assign serial_strobe = r_strobe;
    assign rd_addr       = r_rd_addr;

endmodule
`default_nettype wire

// File: tb/tb_serial_cmd_port.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_cmd_port
// Brief   : Randomized frame-level bench for serial_cmd_port.
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_cmd_port;
    import serial_cmd_pkg::*;

    localparam int N = 2;

    logic        master_clk = 1'b0;
    logic        reset = 1'b1;
    logic        sclk = 1'b0;
    logic        sen = 1'b0;
    logic        sdi = 1'b0;
    logic        sdo, sdo_oe, serial_strobe;
    logic [6:0]  serial_addr, rd_addr;
    logic [31:0] serial_data;
    logic [31:0] rd_data;

    always #5 master_clk = ~master_clk;

    serial_cmd_port #(.SYNC_STAGES(N)) dut (
        .master_clk(master_clk), .reset(reset), .sclk(sclk), .sen(sen), .sdi(sdi),
        .sdo(sdo), .sdo_oe(sdo_oe), .serial_addr(serial_addr), .serial_data(serial_data),
        .serial_strobe(serial_strobe), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // External readback mux: table lookup with two cycles of latency.
    logic [31:0] rd_mem [128];
    logic [31:0] mux_d1;
    always @(posedge master_clk) begin
        mux_d1  <= rd_mem[rd_addr];
        rd_data <= mux_d1;
    end

    int   n_checks = 0;
    int   n_pass = 0;
    int   strobe_cnt = 0;
    int   width_err = 0;
    int   oe_err = 0;
    bit   oe_ok = 1'b0;
    logic prev_strobe = 1'b0;

    always @(negedge master_clk) begin
        if (serial_strobe) strobe_cnt++;
        if (serial_strobe && prev_strobe) width_err++;
        prev_strobe = serial_strobe;
        if (sdo_oe && !oe_ok) oe_err++;
    end

    logic [6:0]  exp_addr = '0;
    logic [6:0]  exp_rd_addr = '0;
    logic [31:0] exp_data = '0;
    int          exp_strobes = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge master_clk);
        #2;
    endtask

    task automatic drive_bit(input logic b, input bit is_read, input int i, inout logic [31:0] rx);
        sdi = b;
        cyc($urandom_range(5, 7));
        sclk = 1'b1;
        if (is_read && i == 7) oe_ok = 1'b1;
        cyc($urandom_range(5, 7));
        if (is_read && i == 7) begin
            cyc(N + 6);
            check("oe_on", 64'(sdo_oe), 64'(1));
        end
        if (is_read && i >= 7 && i <= 38) rx = {rx[30:0], sdo};
        sclk = 1'b0;
    endtask

    task automatic run_frame(input bit is_read, input logic [6:0] addr, input logic [31:0] data,
                             input int nbits, input int gap);
        logic [39:0] f;
        logic [31:0] rx;
        bit          valid_wr;
        int          gap_total;
        f         = {is_read, addr, data};
        rx        = '0;
        valid_wr  = !is_read && (nbits == FRAME_BITS);
        gap_total = (gap > N + 3) ? gap : N + 3;
        sen = 1'b1;
        cyc(4);
        for (int i = 0; i < nbits; i++) begin
            drive_bit((i < 40) ? f[39-i] : 1'($urandom), is_read, i, rx);
        end
        cyc($urandom_range(5, 7));
        sen = 1'b0;
        if (is_read && nbits >= 8) exp_rd_addr = addr;
        for (int c = 1; c <= gap_total; c++) begin
            cyc(1);
            if (valid_wr && c >= N + 1 && c <= N + 3)
                check("strobe_lat", 64'(serial_strobe), 64'(c == N + 2));
            if (valid_wr && c == N + 2) begin
                check("strobe_addr", 64'(serial_addr), 64'(addr));
                check("strobe_data", 64'(serial_data), 64'(data));
            end
            if (c == N + 1) begin
                if (is_read) check("oe_release", 64'(sdo_oe), 64'(0));
                oe_ok = 1'b0;
            end
        end
        if (valid_wr) begin
            exp_addr = addr;
            exp_data = data;
            exp_strobes++;
        end
        check("hold_addr", 64'(serial_addr), 64'(exp_addr));
        check("hold_data", 64'(serial_data), 64'(exp_data));
        check("rd_addr", 64'(rd_addr), 64'(exp_rd_addr));
        check("strobe_count", 64'(strobe_cnt), 64'(exp_strobes));
        if (is_read && nbits >= FRAME_BITS) check("rd_word", 64'(rx), 64'(rd_mem[addr]));
    endtask

    task automatic reset_mid_frame();
        logic [39:0] f;
        logic [31:0] rx;
        f  = {1'b0, 7'h2A, 32'hCAFE_F00D};
        rx = '0;
        sen = 1'b1;
        cyc(4);
        for (int i = 0; i < 20; i++) drive_bit(f[39-i], 1'b0, i, rx);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        exp_addr = '0;
        exp_data = '0;
        exp_rd_addr = '0;
        cyc(2);
        check("rst_mid_state", 64'(dut.r_state), 64'(ST_FLUSH));
        check("rst_mid_addr", 64'(serial_addr), 64'(0));
        check("rst_mid_data", 64'(serial_data), 64'(0));
        check("rst_mid_rdaddr", 64'(rd_addr), 64'(0));
        check("rst_mid_sdo", 64'({sdo, sdo_oe, serial_strobe}), 64'(0));
        for (int i = 20; i < 40; i++) drive_bit(f[39-i], 1'b0, i, rx);
        check("flush_hold", 64'(dut.r_state), 64'(ST_FLUSH));
        cyc(4);
        sen = 1'b0;
        cyc(N + 3);
        check("flush_idle", 64'(dut.r_state), 64'(ST_IDLE));
        check("flush_nostrobe", 64'(strobe_cnt), 64'(exp_strobes));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 128; i++) rd_mem[i] = $urandom;
        rd_mem[5] = 32'h1234_5678;
        cyc(6);
        check("rst_strobe", 64'(serial_strobe), 64'(0));
        check("rst_sdo", 64'(sdo), 64'(0));
        check("rst_sdo_oe", 64'(sdo_oe), 64'(0));
        check("rst_addr", 64'(serial_addr), 64'(0));
        check("rst_data", 64'(serial_data), 64'(0));
        check("rst_rd_addr", 64'(rd_addr), 64'(0));
        reset = 1'b0;
        cyc(4);

        run_frame(1'b0, 7'h05, 32'hDEAD_BEEF, 40, 10);
        cyc(20);
        check("write_hold_addr", 64'(serial_addr), 64'(7'h05));
        check("write_hold_data", 64'(serial_data), 64'(32'hDEAD_BEEF));
        run_frame(1'b1, 7'h05, 32'h0, 40, 10);
        run_frame(1'b0, 7'h11, 32'h0BAD_CAFE, 39, 8);
        run_frame(1'b0, 7'h12, 32'h1357_9BDF, 40, 8);
        run_frame(1'b0, 7'h13, 32'hFFFF_0000, 41, 8);
        run_frame(1'b0, 7'h14, 32'h2468_ACE0, 40, 8);
        reset_mid_frame();
        run_frame(1'b0, 7'h7F, 32'hA5A5_5A5A, 40, N + 3);
        run_frame(1'b0, 7'h00, 32'h5A5A_A5A5, 40, N + 3);

        for (int k = 0; k < 25; k++) begin
            int          kind;
            int          nb;
            bit          rd;
            logic [6:0]  a;
            logic [31:0] d;
            kind = int'($urandom_range(0, 5));
            a    = 7'($urandom);
            d    = $urandom;
            rd   = (kind == 2 || kind == 3) ? 1'b1 : 1'b0;
            nb   = 40;
            if (kind == 4) begin
                rd = 1'($urandom);
                nb = int'($urandom_range(9, 39));
            end else if (kind == 5) begin
                rd = 1'($urandom);
                nb = 41;
            end
            run_frame(rd, a, d, nb, int'($urandom_range(N + 3, N + 8)));
        end

        check("strobe_width", 64'(width_err), 64'(0));
        check("oe_window", 64'(oe_err), 64'(0));
        check("strobe_total", 64'(strobe_cnt), 64'(exp_strobes));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_cmd_port.md
# serial_cmd_port

Serial command front end feeding the FPGA's settings bus. Deserializes framed command words from the USB controller's three-wire serial pins into one-cycle `serial_addr`/`serial_data`/`serial_strobe` writes for the setting registers. For read frames, it fetches a 32-bit readback word and shifts it back out on a data-out pin. The block sits between the board pins and every settings-bus consumer in the `master_clk` domain.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth for `sclk`/`sen`/`sdi`; legal values are 2–3.
- `master_clk`  in  1  system clock; all logic runs on its rising edge.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `sclk`  in  1  serial clock pin, asynchronous to `master_clk`.
- `sen`  in  1  frame enable pin, active high, asynchronous.
- `sdi`  in  1  serial data in, MSB first, sampled on `sclk` rising edges.
- `sdo`  out  1  serial data out; changes after `sclk` falling edges.
- `sdo_oe`  out  1  output enable for the `sdo` pad.
- `serial_addr`  out  7  settings-bus address.
- `serial_data`  out  32  settings-bus write data.
- `serial_strobe`  out  1  one-cycle write strobe.
- `rd_addr`  out  7  readback select, presented to the external readback mux.
- `rd_data`  in  32  readback word; valid 2 cycles after `rd_addr` changes.

## Operation
- **Frame format**, 40 bits, MSB first:
  - bit 39: R/W̄ (1 = read)
  - bits 38:32: address
  - bits 31:0: data on writes, readback on reads
- **Input path:** all pins pass through `SYNC_STAGES` flops. `sclk` rising and falling edges are detected in `master_clk` by comparing the last two synchronized samples.
- **States:** IDLE, HDR, WDATA, RFETCH, RDATA, FLUSH.
  - **IDLE:** bit counter = 0. On `sen` rising → HDR.
  - **HDR:** shift `sdi` on each `sclk` rise. After 8 bits, latch `addr`/`rw`.
    - If `rw = 0` → WDATA.
    - If `rw = 1`: drive `rd_addr = addr` → RFETCH.
  - **WDATA:** shift 32 data bits. `sen` falling with exactly 40 bits counted → pulse `serial_strobe` → IDLE.
  - **RFETCH:** wait 2 cycles, then load `rd_data` into the output shift register → RDATA.
  - **RDATA:** `sdo_oe = 1`. Present bit 31 at RDATA entry. Shift left on each `sclk` falling edge. 32 bits in total.
  - **FLUSH:** abort state; wait for `sen` low → IDLE. No strobe is issued.
- **Abort conditions** (→ FLUSH, or directly → IDLE if `sen` is already low):
  - `sen` falls before 40 bits.
  - A 41st `sclk` rise occurs.
- **Read frames** never assert `serial_strobe`.
- **Bit counter:** 6 bits, saturates at 41. No wrap.
- **Output holding:** `serial_addr`/`serial_data` update only on the strobe cycle and hold between writes.
- **Simultaneous events:** `sen` falling in the same cycle as an `sclk` rise counts that bit first, then evaluates the frame end.

## Timing
- **Reset values:**
  - `serial_strobe = 0`, `sdo = 0`, `sdo_oe = 0`
  - `serial_addr = 0`, `serial_data = 0`, `rd_addr = 0`
  - state = IDLE, counter = 0
- **Reset mid-frame:** returns to IDLE next cycle. If `sen` is still high, the block stays in FLUSH until `sen` is low. The partial frame is discarded.
- **Pin-to-edge latency:** `SYNC_STAGES + 1` cycles from a pin transition to the detected edge.
- **`serial_strobe` latency:** asserted `SYNC_STAGES + 2` cycles after the `sen` pin falls. Exactly 1 cycle wide, with `serial_addr`/`serial_data` valid in that same cycle.
- **Read turnaround:**
  - `rd_addr` is valid 1 cycle after the 8th `sclk` rise is detected.
  - `rd_data` is captured 2 cycles later.
  - The host must leave ≥ `SYNC_STAGES + 6` `master_clk` cycles between the 8th rising edge and the next falling `sclk`.
- **SCLK constraint:** `sclk` high time and low time each ≥ `SYNC_STAGES + 2` `master_clk` periods.
- **`sdo_oe` release:** `sdo_oe` drops within `SYNC_STAGES + 1` cycles of `sen` falling.

## Structure
- **Package `serial_cmd_pkg`:**
  - state enum
  - `FRAME_BITS = 40`, `HDR_BITS = 8`, `ADDR_W = 7`, `DATA_W = 32`
  - `RD_LATENCY = 2`
- **Sub-module `pin_sync`:** N-stage synchronizer plus rise/fall edge detect. Instantiated once per pin, for `sclk`, `sen`, and `sdi`.
- **Top level:** FSM, counter, input shift register, and output shift register.

## Test plan
- **Write:** frame 0x05_DEADBEEF → one strobe with `serial_addr = 5`, `serial_data = 0xDEADBEEF`. Outputs hold afterwards.
- **Read:** frame header 0x85, external mux returns 0x12345678 for addr 5 → `rd_addr = 5`. `sdo` emits 0x12345678 MSB first. `sdo_oe` is high for the data phase only. No strobe.
- **Short frame:** `sen` drops after 39 bits → no strobe, outputs unchanged, next valid frame accepted.
- **Long frame:** 41 `sclk` rises → FLUSH, no strobe. After `sen` low, the following frame succeeds.
- **Reset mid-frame:** `reset` at bit 20 with `sen` held high → state FLUSH, no strobe until a fresh frame. All outputs equal their reset values.
- **Back-to-back:** two writes with minimum `sen` low gap of `SYNC_STAGES + 3` cycles → two strobes, each with correct data.
